md5_block_packer: RTL

- Streaming front-end for the MD5 datapath.
- Accepts an arbitrary-length message one byte per cycle with valid/ready/last.
- Packs bytes into 512-bit blocks and applies MD5 padding in hardware (0x80, zero fill, 64-bit little-endian bit length).
- Emits blocks through a valid/ready handshake. blk_first/blk_last tell the controller whether to start or resume the core. This replaces fixed-message block selection with a runtime byte source.

---
 rtl/md5_pkg.sv | 32 +++
 rtl/md5_pad_insert.sv | 37 +++
 rtl/md5_block_packer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/md5_pkg.sv
// Shared constants, state/mode encodings and length helper for the MD5 block packer.
package md5_pkg;

  localparam int BLOCK_BITS  = 512;
  localparam int BLOCK_BYTES = 64;
  localparam int LEN_OFFSET  = 56;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_PAD,
    ST_EMIT,
    ST_EMIT_LEN
  } state_t;

  typedef enum logic [1:0] {
    PM_PAD_AND_LEN,
    PM_PAD_ONLY,
    PM_LEN_ONLY,
    PM_LEN_LEAD80
  } pad_mode_t;

  // Byte i of the result (bits [8i:8i+7]) is byte i of the length, least significant first.
  function automatic logic [0:63] len_to_le_bytes(input logic [63:0] bit_len);
    logic [0:63] le;
    for (int i = 0; i < 8; i++) begin
      le[8*i +: 8] = bit_len[8*i +: 8];
    end
    return le;
  endfunction

endpackage

// File: rtl/md5_pad_insert.sv
// Combinational padding stage: places 0x80, zero fill and the little-endian bit length
// into a block according to the selected mode. Sequencing lives in the parent.
module md5_pad_insert
  import md5_pkg::*;
(
  input  logic [0:BLOCK_BITS-1] blk_in,
  input  logic [6:0]            pos,
  input  logic [63:0]           bit_len,
  input  pad_mode_t             mode,
  output logic [0:BLOCK_BITS-1] blk_out
);

  logic [0:63] len_bytes;

  assign len_bytes = len_to_le_bytes(bit_len);

  always_comb begin
    blk_out = '0;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      if (mode == PM_PAD_AND_LEN || mode == PM_PAD_ONLY) begin
        if (7'(k) < pos) begin
          blk_out[8*k +: 8] = blk_in[8*k +: 8];
        end else if (7'(k) == pos) begin
          blk_out[8*k +: 8] = PAD_BYTE;
        end
      end
      // Length modes only apply with pos <= 55, so this never overwrites the 0x80.
      if (mode != PM_PAD_ONLY && k >= LEN_OFFSET) begin
        blk_out[8*k +: 8] = len_bytes[8*(k-LEN_OFFSET) +: 8];
      end
      if (mode == PM_LEN_LEAD80 && k == 0) begin
        blk_out[8*k +: 8] = PAD_BYTE;
      end
    end
  end

endmodule

// File: rtl/md5_block_packer.sv
// Byte-stream to 512-bit MD5 block packer with hardware padding and length append.
// state       | meaning
// ST_FILL     | accepting message bytes into the buffer
// ST_PAD      | one cycle: write padding into the buffer
// ST_EMIT     | presenting data or padded block
// ST_EMIT_LEN | presenting trailing length-only block
module md5_block_packer
  import md5_pkg::*;
#(
  parameter int LEN_W = 61
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  input  logic                  s_nobyte,
  output logic                  s_ready,
  output logic [0:BLOCK_BITS-1] blk_data,
  output logic                  blk_valid,
  input  logic                  blk_ready,
  output logic                  blk_first,
  output logic                  blk_last
);

  state_t                state_q, state_d;
  logic [0:BLOCK_BITS-1] buf_q;
  logic [6:0]            pos_q;
  logic [LEN_W-1:0]      count_q;
  logic                  first_pending_q;
  logic                  last_q;
  logic                  len_pending_q;
  logic                  lead80_q;

  logic                  carry_byte;
  logic                  accept;
  logic                  handshake;
  pad_mode_t             pad_mode;
  logic [LEN_W+2:0]      bit_len_raw;
  logic [63:0]           bit_len;
  logic [0:BLOCK_BITS-1] padded;

  assign carry_byte  = !(s_last && s_nobyte);
  assign accept      = s_valid && s_ready;
  assign handshake   = blk_valid && blk_ready;
  assign bit_len_raw = {count_q, 3'b000};
  assign bit_len     = 64'(bit_len_raw);

  md5_pad_insert u_pad (
    .blk_in  (buf_q),
    .pos     (pos_q),
    .bit_len (bit_len),
    .mode    (pad_mode),
    .blk_out (padded)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    s_ready   = 1'b0;
    blk_valid = 1'b0;
    pad_mode  = PM_PAD_AND_LEN;
    case (state_q)
      ST_FILL: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (s_last) begin
            state_d = ST_PAD;
          end else if (pos_q == 7'd63) begin
            state_d = ST_EMIT;
          end
        end
      end
      ST_PAD: begin
        state_d  = ST_EMIT;
        pad_mode = (pos_q <= 7'd55) ? PM_PAD_AND_LEN : PM_PAD_ONLY;
      end
      ST_EMIT: begin
        blk_valid = 1'b1;
        pad_mode  = lead80_q ? PM_LEN_LEAD80 : PM_LEN_ONLY;
        if (blk_ready) begin
          state_d = len_pending_q ? ST_EMIT_LEN : ST_FILL;
        end
      end
      ST_EMIT_LEN: begin
        blk_valid = 1'b1;
        if (blk_ready) begin
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q           <= '0;
      pos_q           <= '0;
      count_q         <= '0;
      first_pending_q <= 1'b1;
      last_q          <= 1'b0;
      len_pending_q   <= 1'b0;
      lead80_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (accept) begin
            last_q        <= 1'b0;
            len_pending_q <= 1'b0;
            if (carry_byte) begin
              buf_q[{pos_q[5:0], 3'b000} +: 8] <= s_data;
              pos_q   <= pos_q + 7'd1;
              count_q <= count_q + LEN_W'(1);
            end
          end
        end
        ST_PAD: begin
          if (pos_q <= 7'd55) begin
            buf_q         <= padded;
            last_q        <= 1'b1;
            len_pending_q <= 1'b0;
          end else if (pos_q <= 7'd63) begin
            buf_q         <= padded;
            last_q        <= 1'b0;
            len_pending_q <= 1'b1;
            lead80_q      <= 1'b0;
          end else begin
            // Last byte filled the block: send it untouched, 0x80 opens the length block.
            last_q        <= 1'b0;
            len_pending_q <= 1'b1;
            lead80_q      <= 1'b1;
          end
        end
        ST_EMIT, ST_EMIT_LEN: begin
          if (handshake) begin
            first_pending_q <= 1'b0;
            pos_q           <= '0;
            if (state_q == ST_EMIT && len_pending_q) begin
              buf_q         <= padded;
              last_q        <= 1'b1;
              len_pending_q <= 1'b0;
            end else begin
              buf_q <= '0;
            end
            if (last_q) begin
              count_q         <= '0;
              first_pending_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign blk_data  = buf_q;
  assign blk_first = blk_valid && first_pending_q;
  assign blk_last  = blk_valid && last_q;

endmodule
